// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states and frame geometry.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE
  } state_e;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CSUM_BYTES     = 1;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  // Total byte count of a well-formed frame carrying n words.
  function automatic int unsigned frame_bytes(input int unsigned n);
    return HDR_BYTES + BYTES_PER_WORD * n + CSUM_BYTES;
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Packs stream bytes little-endian into a 32-bit instruction word.
module imem_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  shift_en_i,
  input  logic [7:0]            byte_i,
  input  logic [BYTE_IDX_W-1:0] byte_idx_i,
  output logic [31:0]           word_o,
  output logic                  last_byte_o
);

  logic [31:0] word_q;

  // Byte k of the word lands in lane k; cleared at session start.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      word_q <= '0;
    end else if (clr_i) begin
      word_q <= '0;
    end else if (shift_en_i) begin
      word_q[{byte_idx_i, 3'b000} +: 8] <= byte_i;
    end
  end

  assign word_o      = word_q;
  assign last_byte_o = shift_en_i && (byte_idx_i == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a framed byte stream, writes assembled words into instruction memory
// and holds the core in reset until a load completes with a good checksum.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter bit          BOOT_HOLD  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err_checksum,
  output logic                  err_overflow
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  state_e                  state_q;
  logic [7:0]              n_lo_q;
  logic [15:0]             n_q;
  logic [15:0]             wcnt_q;
  logic [BYTE_IDX_W-1:0]   byte_idx_q;
  logic [7:0]              acc_q;
  logic                    rx_ready_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    ecs_q;
  logic                    eov_q;
  logic                    core_rst_q;

  logic                    xfer;
  logic                    session_start;
  logic                    shift_en;
  logic                    last_byte;
  logic [31:0]             asm_word;
  logic [15:0]             n_full;
  logic                    n_over;
  logic                    last_word;

  assign xfer          = rx_valid && rx_ready_q;
  assign session_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign shift_en      = xfer && (state_q == S_DATA);
  assign n_full        = {rx_data, n_lo_q};
  assign n_over        = ({16'd0, n_full} > DEPTH);
  assign last_word     = (wcnt_q == (n_q - 16'd1));

  imem_word_assembler u_asm (
    .clk_i       (clk),
    .rst_n_i     (rst),
    .clr_i       (session_start),
    .shift_en_i  (shift_en),
    .byte_i      (rx_data),
    .byte_idx_i  (byte_idx_q),
    .word_o      (asm_word),
    .last_byte_o (last_byte)
  );

  // Session FSM; rx_ready is registered alongside each state change so it
  // always matches the state it enables.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      n_lo_q     <= '0;
      n_q        <= '0;
      wcnt_q     <= '0;
      byte_idx_q <= '0;
      acc_q      <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ecs_q      <= 1'b0;
      eov_q      <= 1'b0;
      core_rst_q <= BOOT_HOLD;
    end else begin
      if (xfer && (state_q == S_LEN_LO || state_q == S_LEN_HI || state_q == S_DATA)) begin
        acc_q <= acc_q ^ rx_data;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (state_q == S_DONE && !ecs_q && !eov_q) begin
            core_rst_q <= 1'b0;
          end
          if (start) begin
            state_q    <= S_LEN_LO;
            rx_ready_q <= 1'b1;
            done_q     <= 1'b0;
            ecs_q      <= 1'b0;
            eov_q      <= 1'b0;
            acc_q      <= '0;
            wcnt_q     <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b1;
            core_rst_q <= 1'b1;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            n_lo_q  <= rx_data;
            state_q <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            n_q <= n_full;
            if (n_over) begin
              eov_q      <= 1'b1;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              rx_ready_q <= 1'b0;
              state_q    <= S_DONE;
            end else if (n_full == 16'd0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            byte_idx_q <= byte_idx_q + 1'b1;
            if (last_byte) begin
              we_q       <= 1'b1;
              addr_q     <= wcnt_q[ADDR_WIDTH-1:0];
              rx_ready_q <= 1'b0;
              state_q    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          we_q       <= 1'b0;
          wcnt_q     <= wcnt_q + 16'd1;
          rx_ready_q <= 1'b1;
          state_q    <= last_word ? S_CSUM : S_DATA;
        end
        S_CSUM: begin
          if (xfer) begin
            ecs_q      <= (rx_data != acc_q);
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            rx_ready_q <= 1'b0;
            state_q    <= S_DONE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          rx_ready_q <= 1'b0;
          we_q       <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = asm_word;
  assign core_rst     = core_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_checksum = ecs_q;
  assign err_overflow = eov_q;

endmodule
